hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Drives ID_EX_flush into the ID/EX pipeline register, and drives the PC, IF/ID and whole-pipeline hold controls.
- Detects the following hazards:
  - load-use hazards;
  - branch-operand hazards (branches resolve in ID);
  - taken-branch flushes;
  - multi-cycle data-memory waits, with a timeout fault.
- Maintains saturating performance counters for stalls, flushes and freezes.

Parameters:
CNT_WIDTH, 16, width of each performance counter
MEM_TIMEOUT, 64, number of consecutive mem_busy cycles that trigger FAULT
WAIT_WIDTH, 7, width of the internal wait counter; must hold MEM_TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
ID_registers_Rs  in  5  Rs of the instruction in ID
ID_registers_Rt  in  5  Rt of the instruction in ID
ID_uses_Rt  in  1  the ID instruction reads Rt as a source
ID_is_branch  in  1  the ID instruction is beq/bne
ID_branch_taken  in  1  branch compare result; meaningful only when no stall is raised
EX_MemRead  in  1  the EX instruction is a load
EX_RegWrite  in  1  the EX instruction writes a register
EX_write_reg  in  5  destination register in EX (after RegDst mux)
MEM_MemRead  in  1  the MEM instruction is a load
MEM_register_Rt  in  5  load destination in MEM
mem_busy  in  1  data memory has not completed this cycle
PC_write  out  1  PC update enable
IF_ID_write  out  1  IF/ID register enable
IF_ID_flush  out  1  squash the IF/ID instruction
ID_EX_flush  out  1  insert a bubble into ID/EX
pipe_hold  out  1  freeze the ID/EX, EX/MEM and MEM/WB registers
fault  out  1  sticky memory-timeout fault
stall_cnt  out  CNT_WIDTH  cycles with a bubble inserted
flush_cnt  out  CNT_WIDTH  taken-branch flushes
freeze_cnt  out  CNT_WIDTH  cycles with pipe_hold=1

Behaviour:
Combinational hazard terms (a source match counts only when the register is nonzero):
- match(r): r != 0 and (r == Rs, or ID_uses_Rt and r == Rt).
- load_use = EX_MemRead and match(EX_write_reg).
- br_ex = ID_is_branch and EX_RegWrite and match(EX_write_reg).
- br_mem = ID_is_branch and MEM_MemRead and match(MEM_register_Rt).
- stall = load_use or br_ex or br_mem.
- take = ID_is_branch and ID_branch_taken and not stall.

FSM states are RUN, MEM_WAIT and FAULT; state is registered.
- RUN:
  - mem_busy=1 goes to MEM_WAIT, wait_cnt←1.
  - Otherwise stays in RUN.
- MEM_WAIT:
  - mem_busy=0 goes to RUN, wait_cnt←0.
  - mem_busy=1 with wait_cnt == MEM_TIMEOUT-1 goes to FAULT.
  - Otherwise wait_cnt increments.
- FAULT: absorbing until rst.

freeze = mem_busy or state==FAULT. The freeze is applied combinationally in the first busy cycle.

Output priority (combinational from state and inputs):
1. freeze:
   - PC_write=0, IF_ID_write=0, pipe_hold=1.
   - Both flushes are 0, so no bubble is inserted and the frozen instruction is preserved.
2. Else stall:
   - PC_write=0, IF_ID_write=0, ID_EX_flush=1.
   - IF_ID_flush=0, pipe_hold=0.
3. Else take:
   - PC_write=1, IF_ID_write=1, IF_ID_flush=1.
   - ID_EX_flush=0, pipe_hold=0.
4. Else: PC_write=1, IF_ID_write=1, all other control outputs 0.

Resulting stall sequences:
- A branch dependent on a load in EX stalls 2 cycles: load_use, then br_mem.
- A branch dependent on an ALU op in EX stalls 1 cycle.
- A non-branch load-use stalls exactly 1 cycle.

fault is 1 exactly when state==FAULT.

Counters, registered and saturating at all-ones:
- stall_cnt increments in cycles with output case 2.
- flush_cnt increments in case 3.
- freeze_cnt increments in case 1.

Reset (synchronous, highest priority):
- state←RUN, wait_cnt←0, all counters←0.
- Outputs during the rst cycle follow the combinational rules with state=RUN.
- rst asserted during MEM_WAIT or FAULT returns to RUN on the next edge.

Simultaneous events:
- mem_busy overrides stall and take.
- stall suppresses take: the branch is re-evaluated once operands are ready.
- Register $0 never causes a hazard.

Test Plan:
- Load-use: EX_MemRead=1, EX_write_reg=8, ID Rs=8, no mem_busy → exactly 1 cycle of PC_write=0, IF_ID_write=0, ID_EX_flush=1; stall_cnt=1.
- Branch after load: lw $9 in EX, beq using $9 in ID, taken → 2 stall cycles (load_use, then br_mem), then IF_ID_flush=1 for 1 cycle; stall_cnt=2, flush_cnt=1.
- $0 / Rt filter:
  - EX load to $0 with ID Rs=0 → no stall.
  - EX load to $5 with ID Rt=5 and ID_uses_Rt=0 → no stall.
- Memory wait: mem_busy high 3 cycles during a load_use condition → pipe_hold=1 and ID_EX_flush=0 for 3 cycles, then 1 stall cycle; freeze_cnt=3, state back to RUN.
- Timeout: mem_busy held high for 70 cycles with MEM_TIMEOUT=64 → fault=1 from the edge ending the 64th busy cycle; fault and pipe_hold persist after mem_busy drops; rst → fault=0, counters=0, state RUN.
- Saturation: CNT_WIDTH=4, 20 consecutive stall cycles → stall_cnt stops at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard, stall and memory-wait controller for the 5-stage core
//
// Ports:
//   clk, rst                       clock (rising edge), synchronous active-high reset
//   ID_registers_Rs/Rt, ID_uses_Rt source operands of the instruction in ID
//   ID_is_branch, ID_branch_taken  branch in ID and its compare result
//   EX_MemRead, EX_RegWrite,
//   EX_write_reg                   producer in EX
//   MEM_MemRead, MEM_register_Rt   load in MEM
//   mem_busy                       data memory not done this cycle
//   PC_write, IF_ID_write          front-end enables
//   IF_ID_flush, ID_EX_flush       squash IF/ID, bubble into ID/EX
//   pipe_hold                      freeze ID/EX, EX/MEM, MEM/WB
//   fault                          sticky memory-timeout fault
//   stall_cnt, flush_cnt,
//   freeze_cnt                     saturating performance counters
module hazard_ctrl #(
    parameter int CNT_WIDTH   = 16,
    parameter int MEM_TIMEOUT = 64,
    parameter int WAIT_WIDTH  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           ID_registers_Rs,
    input  logic [4:0]           ID_registers_Rt,
    input  logic                 ID_uses_Rt,
    input  logic                 ID_is_branch,
    input  logic                 ID_branch_taken,
    input  logic                 EX_MemRead,
    input  logic                 EX_RegWrite,
    input  logic [4:0]           EX_write_reg,
    input  logic                 MEM_MemRead,
    input  logic [4:0]           MEM_register_Rt,
    input  logic                 mem_busy,
    output logic                 PC_write,
    output logic                 IF_ID_write,
    output logic                 IF_ID_flush,
    output logic                 ID_EX_flush,
    output logic                 pipe_hold,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt,
    output logic [CNT_WIDTH-1:0] freeze_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [WAIT_WIDTH-1:0] wait_cnt, wait_nxt;

    logic ex_match, mem_match;
    logic load_use, br_ex, br_mem, stall, take, freeze;

    // $0 is hardwired, so a producer targeting it never creates a dependency.
    always_comb begin
        ex_match  = (EX_write_reg != 5'd0) &&
                    ((EX_write_reg == ID_registers_Rs) ||
                     (ID_uses_Rt && (EX_write_reg == ID_registers_Rt)));
        mem_match = (MEM_register_Rt != 5'd0) &&
                    ((MEM_register_Rt == ID_registers_Rs) ||
                     (ID_uses_Rt && (MEM_register_Rt == ID_registers_Rt)));
        load_use  = EX_MemRead && ex_match;
        br_ex     = ID_is_branch && EX_RegWrite && ex_match;
        br_mem    = ID_is_branch && MEM_MemRead && mem_match;
        stall     = load_use || br_ex || br_mem;
        // A stalled branch has stale operands; it is re-evaluated once they arrive.
        take      = ID_is_branch && ID_branch_taken && !stall;
        // In the reset cycle outputs behave as if the FSM were already in RUN.
        freeze    = mem_busy || ((state == FAULT) && !rst);
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_WIDTH'(1);
                end
            end
            MEM_WAIT: begin
                if (!mem_busy) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt == WAIT_WIDTH'(MEM_TIMEOUT - 1)) begin
                    state_nxt = FAULT;
                end else begin
                    wait_nxt = wait_cnt + WAIT_WIDTH'(1);
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Freeze keeps both flushes low so the held instruction is not lost.
    always_comb begin
        PC_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        pipe_hold   = 1'b0;
        if (freeze) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            pipe_hold   = 1'b1;
        end else if (stall) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
        end else if (take) begin
            IF_ID_flush = 1'b1;
        end
    end

    assign fault = (state == FAULT);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            freeze_cnt <= '0;
        end else begin
            if (freeze) begin
                if (freeze_cnt != '1) freeze_cnt <= freeze_cnt + CNT_WIDTH'(1);
            end else if (stall) begin
                if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end else if (take) begin
                if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
